// File: rtl/alarm_key_fsm.sv
// alarm_key_fsm: main keypad control FSM of the alarm clock.
// It sequences keypad entry of a new time. It commits the entry as the alarm
// time or as the current time. It abandons entry after an idle timeout counted
// in one_second pulses.
// Ports:
//   clock, reset     - system clock, asynchronous active-high reset
//   one_second       - one-cycle pulse from the time generator
//   key[3:0]         - level keypad code (0-9 digit, A alarm, B time, F none)
//   show_new_time    - display the key buffer
//   show_alarm       - display the alarm register
//   shift            - key buffer shifts in key (one pulse per key press)
//   load_new_alarm   - alarm register loads the key buffer
//   load_new_time    - current-time register loads the key buffer
//   reset_count      - re-synchronise the time generator (with load_new_time)
module alarm_key_fsm #(
    parameter int unsigned TIMEOUT_SECONDS = 10,
    parameter int unsigned CNT_W           = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic [3:0] key,
    output logic       show_new_time,
    output logic       show_alarm,
    output logic       shift,
    output logic       load_new_alarm,
    output logic       load_new_time,
    output logic       reset_count
);

    localparam logic [3:0] KEY_ALARM = 4'hA;
    localparam logic [3:0] KEY_TIME  = 4'hB;
    localparam logic [3:0] KEY_NONE  = 4'hF;

    typedef enum logic [2:0] {
        SHOW_TIME  = 3'd0,
        SHOW_ALARM = 3'd1,
        KEY_STORED = 3'd2,
        KEY_WAITED = 3'd3,
        KEY_ENTRY  = 3'd4,
        SET_ALARM  = 3'd5,
        SET_TIME   = 3'd6
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] timeout_cnt;
    logic             timeout;
    logic             is_digit;
    logic             in_entry;

    assign is_digit = (key <= 4'd9);
    assign in_entry = (state == KEY_ENTRY) || (state == KEY_WAITED);
    assign timeout  = (timeout_cnt == CNT_W'(TIMEOUT_SECONDS));

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= SHOW_TIME;
        end else begin
            state <= state_next;
        end
    end

    // Idle timeout counter: runs only while waiting for keys, saturates at the limit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeout_cnt <= '0;
        end else if (!in_entry) begin
            timeout_cnt <= '0;
        end else if (one_second && !timeout) begin
            timeout_cnt <= timeout_cnt + CNT_W'(1);
        end
    end

    // Next-state logic; key actions are tested before timeout so they win
    always_comb begin
        state_next = state;
        case (state)
            SHOW_TIME: begin
                if (key == KEY_ALARM) begin
                    state_next = SHOW_ALARM;
                end else if (is_digit) begin
                    state_next = KEY_STORED;
                end
            end
            SHOW_ALARM: begin
                if (key != KEY_ALARM) begin
                    state_next = SHOW_TIME;
                end
            end
            KEY_STORED: begin
                state_next = KEY_WAITED;
            end
            KEY_WAITED: begin
                if (key == KEY_NONE) begin
                    state_next = KEY_ENTRY;
                end else if (timeout) begin
                    state_next = SHOW_TIME;
                end
            end
            KEY_ENTRY: begin
                if (key == KEY_ALARM) begin
                    state_next = SET_ALARM;
                end else if (key == KEY_TIME) begin
                    state_next = SET_TIME;
                end else if (is_digit) begin
                    state_next = KEY_STORED;
                end else if (timeout) begin
                    state_next = SHOW_TIME;
                end
            end
            SET_ALARM: begin
                state_next = SHOW_TIME;
            end
            SET_TIME: begin
                state_next = SHOW_TIME;
            end
            default: begin
                state_next = SHOW_TIME;
            end
        endcase
    end

    // Moore output decode from the current state only
    always_comb begin
        show_new_time  = 1'b0;
        show_alarm     = 1'b0;
        shift          = 1'b0;
        load_new_alarm = 1'b0;
        load_new_time  = 1'b0;
        reset_count    = 1'b0;
        case (state)
            SHOW_ALARM: begin
                show_alarm = 1'b1;
            end
            KEY_STORED: begin
                shift         = 1'b1;
                show_new_time = 1'b1;
            end
            KEY_WAITED, KEY_ENTRY: begin
                show_new_time = 1'b1;
            end
            SET_ALARM: begin
                load_new_alarm = 1'b1;
            end
            SET_TIME: begin
                load_new_time = 1'b1;
                reset_count   = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_alarm_key_fsm.sv
// Scoreboard bench for alarm_key_fsm. The stimulus process queues the expected
// output vector for the state after each clock edge. The monitor pops and
// compares the vector on the falling edge of that same cycle.
module tb_alarm_key_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       one_second = 1'b0;
    logic [3:0] key = 4'hF;
    logic       show_new_time, show_alarm, shift;
    logic       load_new_alarm, load_new_time, reset_count;
    logic [5:0] outs;

    // Vector order: {show_new_time, show_alarm, shift, load_new_alarm, load_new_time, reset_count}
    localparam logic [5:0] O_IDLE   = 6'b000000;
    localparam logic [5:0] O_ALM    = 6'b010000;
    localparam logic [5:0] O_STORED = 6'b101000;
    localparam logic [5:0] O_NEW    = 6'b100000;
    localparam logic [5:0] O_SETA   = 6'b000100;
    localparam logic [5:0] O_SETT   = 6'b000011;

    typedef struct {
        int         cyc;
        logic [5:0] exp;
        int         id;
    } sb_t;

    sb_t sb[$];
    int  tb_cycle = 0;
    int  total = 0;
    int  bad = 0;

    alarm_key_fsm #(.TIMEOUT_SECONDS(10), .CNT_W(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .one_second     (one_second),
        .key            (key),
        .show_new_time  (show_new_time),
        .show_alarm     (show_alarm),
        .shift          (shift),
        .load_new_alarm (load_new_alarm),
        .load_new_time  (load_new_time),
        .reset_count    (reset_count)
    );

    assign outs = {show_new_time, show_alarm, shift, load_new_alarm, load_new_time, reset_count};

    always #5 clock = ~clock;

    always @(posedge clock) tb_cycle <= tb_cycle + 1;

    task automatic check(input string name, input int id, input logic [5:0] act, input logic [5:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s #%0d: got %b expected %b (t=%0t)", name, id, act, exp, $time);
        end
    endtask

    // Monitor: compare every queued expectation due in the current cycle
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= tb_cycle) begin
            sb_t e;
            e = sb.pop_front();
            check("outputs", e.id, outs, e.exp);
        end
    end

    int step_id = 0;

    // Drive the inputs for one cycle. Queue the outputs expected after the next edge.
    task automatic drive(input logic [3:0] k, input logic os, input logic [5:0] exp);
        sb_t e;
        key        = k;
        one_second = os;
        e.cyc = tb_cycle + 1;
        e.exp = exp;
        e.id  = step_id;
        step_id++;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        check("in_reset", 0, outs, O_IDLE);
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(4'hF, 1'b0, O_IDLE);

        // Four digits with release gaps, then TIME commit
        for (int d = 1; d <= 4; d++) begin
            drive(4'(d), 1'b0, O_STORED);
            drive(4'(d), 1'b0, O_NEW);
            drive(4'(d), 1'b0, O_NEW);
            for (int i = 0; i < 3; i++) drive(4'hF, 1'b0, O_NEW);
        end
        drive(4'hB, 1'b0, O_SETT);
        drive(4'hF, 1'b0, O_IDLE);
        drive(4'hF, 1'b0, O_IDLE);

        // Long-held digit gives one shift, then ALARM commit and held ALARM display
        drive(4'h7, 1'b0, O_STORED);
        for (int i = 0; i < 19; i++) drive(4'h7, 1'b0, O_NEW);
        drive(4'hF, 1'b0, O_NEW);
        drive(4'hA, 1'b0, O_SETA);
        drive(4'hA, 1'b0, O_IDLE);
        drive(4'hA, 1'b0, O_ALM);
        drive(4'hF, 1'b0, O_IDLE);

        // ALARM display from SHOW_TIME
        for (int i = 0; i < 5; i++) drive(4'hA, 1'b0, O_ALM);
        drive(4'hF, 1'b0, O_IDLE);

        // Timeout from KEY_ENTRY
        drive(4'h5, 1'b0, O_STORED);
        drive(4'hF, 1'b0, O_NEW);
        drive(4'hF, 1'b0, O_NEW);
        for (int i = 0; i < 10; i++) drive(4'hF, 1'b1, O_NEW);
        drive(4'hF, 1'b0, O_IDLE);
        drive(4'hF, 1'b0, O_IDLE);

        // Digit on the exit edge wins over timeout; counter restarts
        drive(4'h5, 1'b0, O_STORED);
        drive(4'hF, 1'b0, O_NEW);
        drive(4'hF, 1'b0, O_NEW);
        for (int i = 0; i < 10; i++) drive(4'hF, 1'b1, O_NEW);
        drive(4'h3, 1'b0, O_STORED);
        drive(4'h3, 1'b0, O_NEW);
        // Stuck key: nine pulses and an idle cycle must not time out yet
        for (int i = 0; i < 9; i++) drive(4'h3, 1'b1, O_NEW);
        drive(4'h3, 1'b0, O_NEW);
        drive(4'h3, 1'b1, O_NEW);
        drive(4'h3, 1'b0, O_IDLE);
        drive(4'hF, 1'b0, O_IDLE);
        drive(4'hF, 1'b0, O_IDLE);

        // Asynchronous reset while in KEY_WAITED with the counter at 5
        drive(4'h8, 1'b0, O_STORED);
        drive(4'h8, 1'b0, O_NEW);
        for (int i = 0; i < 5; i++) drive(4'h8, 1'b1, O_NEW);
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset", 1, outs, O_IDLE);
        total++;
        if (dut.timeout_cnt !== 4'd0) begin
            bad++;
            $display("FAIL reset_counter: got %0d expected 0", dut.timeout_cnt);
        end
        @(posedge clock);
        #1;
        check("held_reset", 2, outs, O_IDLE);
        reset = 1'b0;
        drive(4'hF, 1'b0, O_IDLE);
        total++;
        if (dut.timeout_cnt !== 4'd0) begin
            bad++;
            $display("FAIL post_reset_counter: got %0d expected 0", dut.timeout_cnt);
        end
        drive(4'h2, 1'b0, O_STORED);
        drive(4'hF, 1'b0, O_NEW);

        // Drain the scoreboard
        @(posedge clock);
        @(negedge clock);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
